// File: rtl/sram_param_rw_pkg.sv
// Shared types and helpers for the parametrised SRAM and its clear sequencer.
package sram_pkg;

  // Read-during-write policy encodings for the RDW_MODE parameter
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the byte-merge helper can handle; narrower words are zero-extended
  localparam int MaxWidth = 1024;
  localparam int MaxBytes = MaxWidth / 8;

  typedef logic [MaxWidth-1:0] word_t;
  typedef logic [MaxBytes-1:0] be_t;

  // Clear sequencer states: sweeping zeros through the array, or open for access
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } sram_state_e;

  // Replace the bytes of oldWord selected by be with the matching bytes of newWord
  function automatic word_t byteMerge(input word_t oldWord, input word_t newWord, input be_t be);
    word_t result;
    result = oldWord;
    for (int i = 0; i < MaxBytes; i++) begin
      if (be[i]) begin
        result[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_param_rw_if.sv
// Client-facing access bus of the SRAM: master is the client, slave is the memory.
interface sram_param_rw_if #(
  parameter int WIDTH = 128,
  parameter int NUM   = 2048,
  parameter int AW    = $clog2(NUM)
);
  import sram_pkg::*;

  logic             cen;
  logic             wen;
  logic             ren;
  logic [WIDTH/8-1:0] be;
  logic [AW-1:0]    a;
  logic [WIDTH-1:0] d;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic             qValid;
  logic             ready;

  modport master (
    output cen, wen, ren, be, a, d, clr,
    input  q, qValid, ready
  );

  modport slave (
    input  cen, wen, ren, be, a, d, clr,
    output q, qValid, ready
  );

endinterface

// File: rtl/sram_param_rw_clear_seq.sv
// Clear sequencer: after reset or a clear request, walks every address once
// with a write-zero strobe, then opens the array to clients via ready_o.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int NUM = 2048,
  parameter int AW  = $clog2(NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          ready_o,
  output logic          clrWe_o,
  output logic [AW-1:0] clrAddr_o
);

  sram_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and sweep counter; reset lands in CLEAR so a full sweep follows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep to the last word, then idle until a clear request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == AW'(NUM - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: ready while idle, one zero-write per cycle while clearing
  always_comb begin
    ready_o   = (state_q == IDLE);
    clrWe_o   = (state_q == CLEAR);
    clrAddr_o = cnt_q;
  end

endmodule

// File: rtl/sram_param_rw.sv
// Single-port SRAM with registered read, byte enables, selectable
// read-during-write policy and a hardware clear sweep gating client access.
module sram_param_rw
  import sram_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int NUM      = 2048,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_param_rw_if.slave  bus
);

  localparam int AW    = $clog2(NUM);
  localparam int BYTES = WIDTH / 8;

  if ((WIDTH % 8) != 0) begin : gIllegalWidth
    $error("sram_param_rw: WIDTH must be a multiple of 8");
  end
  if (WIDTH > MaxWidth) begin : gWidthTooLarge
    $error("sram_param_rw: WIDTH exceeds the byte-merge helper limit");
  end
  if (NUM < 2) begin : gIllegalNum
    $error("sram_param_rw: NUM must be at least 2");
  end

  logic [WIDTH-1:0] mem [NUM];

  logic             ready;
  logic             clrWe;
  logic [AW-1:0]    clrAddr;
  logic             userEn;
  logic             inRange;
  logic [WIDTH-1:0] rdWord;
  logic [WIDTH-1:0] merged;
  logic             memWe;
  logic [AW-1:0]    memAddr;
  logic [WIDTH-1:0] memWdata;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qValid_q, qValid_d;

  sram_clear_seq #(
    .NUM (NUM),
    .AW  (AW)
  ) uClearSeq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (bus.clr),
    .ready_o   (ready),
    .clrWe_o   (clrWe),
    .clrAddr_o (clrAddr)
  );

  // Client access decode: only when ready, and a same-cycle clear wins over it
  always_comb begin
    userEn  = ready && !bus.cen && !bus.clr;
    inRange = ({1'b0, bus.a} < (AW + 1)'(NUM));
    rdWord  = inRange ? mem[bus.a] : '0;
  end

  // Byte-merge the incoming data over the current word (zero-extended to the helper width)
  always_comb begin
    word_t oldExt;
    word_t newExt;
    word_t mergedExt;
    be_t   beExt;
    oldExt            = '0;
    newExt            = '0;
    beExt             = '0;
    oldExt[WIDTH-1:0] = rdWord;
    newExt[WIDTH-1:0] = bus.d;
    beExt[BYTES-1:0]  = bus.be;
    mergedExt         = byteMerge(oldExt, newExt, beExt);
    merged            = mergedExt[WIDTH-1:0];
  end

  // Array write port: the clear sweep owns it while active, otherwise the client
  always_comb begin
    memWe    = 1'b0;
    memAddr  = bus.a;
    memWdata = merged;
    if (clrWe) begin
      memWe    = 1'b1;
      memAddr  = clrAddr;
      memWdata = '0;
    end else if (userEn && bus.wen && inRange) begin
      memWe = 1'b1;
    end
  end

  // Storage array; contents are not reset, the sweep zeroes them instead
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memWdata;
    end
  end

  // Read data select: out-of-range reads return zero, write-first forwards the merge
  always_comb begin
    q_d      = q_q;
    qValid_d = 1'b0;
    if (userEn && bus.ren) begin
      qValid_d = 1'b1;
      if (!inRange) begin
        q_d = '0;
      end else if ((RDW_MODE == RDW_WRITE_FIRST) && bus.wen) begin
        q_d = merged;
      end else begin
        q_d = rdWord;
      end
    end
  end

  // Registered read output and its one-cycle valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q      <= '0;
      qValid_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      qValid_q <= qValid_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.qValid = qValid_q;
  assign bus.ready  = ready;

endmodule

// File: tb/tb_sram_param_rw.sv
// Directed bench: a 16-word read-first SRAM (A) and a 12-word write-first SRAM (B)
// share clock and reset and are driven through their own interfaces.
module tb_sram_param_rw;
  import sram_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sram_param_rw_if #(.WIDTH(32), .NUM(16)) ifA ();
  sram_param_rw_if #(.WIDTH(32), .NUM(12)) ifB ();

  sram_param_rw #(.WIDTH(32), .NUM(16), .RDW_MODE(RDW_READ_FIRST)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA.slave)
  );

  sram_param_rw #(.WIDTH(32), .NUM(12), .RDW_MODE(RDW_WRITE_FIRST)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB.slave)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point; observed and expected zero-extended to 32 bits
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one bus (0 = A, 1 = B) with a full set of client inputs
  task automatic applyStimulus(input int sel, input logic cen, input logic wen, input logic ren,
                               input logic [3:0] be, input logic [3:0] a, input logic [31:0] d,
                               input logic clr);
    if (sel == 0) begin
      ifA.cen = cen; ifA.wen = wen; ifA.ren = ren; ifA.be = be; ifA.a = a; ifA.d = d; ifA.clr = clr;
    end else begin
      ifB.cen = cen; ifB.wen = wen; ifB.ren = ren; ifB.be = be; ifB.a = a; ifB.d = d; ifB.clr = clr;
    end
  endtask

  task automatic idleBus(input int sel);
    applyStimulus(sel, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic writeWord(input int sel, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    applyStimulus(sel, 1'b0, 1'b1, 1'b0, be, a, d, 1'b0);
    tick();
    idleBus(sel);
  endtask

  task automatic readCheck(input int sel, input logic [3:0] a, input logic [31:0] exp, input string tag);
    applyStimulus(sel, 1'b0, 1'b0, 1'b1, 4'h0, a, 32'h0, 1'b0);
    tick();
    idleBus(sel);
    if (sel == 0) begin
      checkOutput({tag, "_q"}, ifA.q, exp);
      checkOutput({tag, "_valid"}, {31'b0, ifA.qValid}, 32'h1);
    end else begin
      checkOutput({tag, "_q"}, ifB.q, exp);
      checkOutput({tag, "_valid"}, {31'b0, ifB.qValid}, 32'h1);
    end
  endtask

  // Check READY of both DUTs edge by edge after a sweep start point
  task automatic sweepCheck(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput({tag, "_readyA"}, {31'b0, ifA.ready}, {31'b0, (k >= 16)});
      checkOutput({tag, "_readyB"}, {31'b0, ifB.ready}, {31'b0, (k >= 12)});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idleBus(0);
    idleBus(1);

    // Reset state
    tick();
    tick();
    checkOutput("rst_qA", ifA.q, 32'h0);
    checkOutput("rst_validA", {31'b0, ifA.qValid}, 32'h0);
    checkOutput("rst_readyA", {31'b0, ifA.ready}, 32'h0);
    checkOutput("rst_readyB", {31'b0, ifB.ready}, 32'h0);

    // Sweep length after reset release
    rst_n = 1'b1;
    checkOutput("sweep0_readyA", {31'b0, ifA.ready}, 32'h0);
    sweepCheck("sweep");

    // Back-to-back reads of every word: all zero, one result per cycle
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
      tick();
      checkOutput("zero_q", ifA.q, 32'h0);
      checkOutput("zero_valid", {31'b0, ifA.qValid}, 32'h1);
    end
    idleBus(0);
    tick();
    checkOutput("noread_valid", {31'b0, ifA.qValid}, 32'h0);

    // Byte mask
    writeWord(0, 4'd3, 32'hAABBCCDD, 4'b1111);
    writeWord(0, 4'd3, 32'h11223344, 4'b0101);
    readCheck(0, 4'd3, 32'hAA22CC44, "bytemask");
    writeWord(0, 4'd3, 32'h55555555, 4'b0000);
    readCheck(0, 4'd3, 32'hAA22CC44, "be_zero");

    // Read-during-write on both DUTs at address 5
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0);
    tick();
    idleBus(0);
    idleBus(1);
    checkOutput("rdw_readfirst_q", ifA.q, 32'h0);
    checkOutput("rdw_writefirst_q", ifB.q, 32'hDEADBEEF);
    checkOutput("rdw_writefirst_valid", {31'b0, ifB.qValid}, 32'h1);
    readCheck(0, 4'd5, 32'hDEADBEEF, "rdw_after_A");
    readCheck(1, 4'd5, 32'hDEADBEEF, "rdw_after_B");

    // Write-first with partial byte enables merges over the old word
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 4'b0011, 4'd5, 32'h01234567, 1'b0);
    tick();
    idleBus(1);
    checkOutput("rdw_partial_q", ifB.q, 32'hDEAD4567);

    // Out of range on the 12-word DUT
    writeWord(1, 4'd11, 32'hCAFEF00D, 4'hF);
    writeWord(1, 4'd13, 32'h12345678, 4'hF);
    readCheck(1, 4'd13, 32'h0, "oor_read");
    readCheck(1, 4'd11, 32'hCAFEF00D, "inrange_read");

    // Clear re-sweep with a same-cycle write that must be dropped
    for (int i = 0; i < 16; i++) begin
      writeWord(0, 4'(i), 32'hFFFFFFFF, 4'hF);
    end
    readCheck(0, 4'd2, 32'hFFFFFFFF, "fill");
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'hF, 4'd2, 32'h12345678, 1'b1);
    tick();
    checkOutput("clr0_readyA", {31'b0, ifA.ready}, 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput("clr_readyA", {31'b0, ifA.ready}, {31'b0, (k >= 16)});
      checkOutput("clr_validA", {31'b0, ifA.qValid}, 32'h0);
      checkOutput("clr_holdqA", ifA.q, 32'hFFFFFFFF);
    end
    idleBus(0);
    for (int i = 0; i < 16; i++) begin
      readCheck(0, 4'(i), 32'h0, "postclr");
    end

    // Reset clears Q; then mid-sweep reset restarts a full sweep
    readCheck(1, 4'd11, 32'hCAFEF00D, "prereset");
    rst_n = 1'b0;
    #1;
    checkOutput("rstq_B", ifB.q, 32'h0);
    checkOutput("rstvalid_B", {31'b0, ifB.qValid}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
    end
    checkOutput("mid_readyA", {31'b0, ifA.ready}, 32'h0);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_qA", ifA.q, 32'h0);
    checkOutput("midrst_validA", {31'b0, ifA.qValid}, 32'h0);
    checkOutput("midrst_readyB", {31'b0, ifB.ready}, 32'h0);
    rst_n = 1'b1;
    sweepCheck("resweep");
    readCheck(0, 4'd15, 32'h0, "resweep_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
